// File: rtl/inst_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : inst_mem_pkg
// Description : Shared definitions for the instruction-memory write side
//               (inst_mem_loader) and the read/decode side. Holds the loader
//               FSM state encoding, abort cause codes, the default memory
//               size, and the 16-bit instruction field widths.
//               The CSUM state exists only when INST_MEM_LOADER_CHECKSUM_EN
//               is defined.
// Revision    : 1.0 - initial release
// ============================================================================
package inst_mem_pkg;

    // Default byte capacity of the instruction memory (32 instructions).
    localparam int c_default_mem_bytes = 64;

    // Instruction field widths: opcode | reg | imm = 4 + 3 + 5 = 12 bits used
    // inside the 16-bit instruction word.
    localparam int c_opcode_w = 4;
    localparam int c_reg_w    = 3;
    localparam int c_imm_w    = 5;

    // Abort cause codes reported on err_code.
    localparam logic [1:0] c_err_none     = 2'd0;
    localparam logic [1:0] c_err_odd      = 2'd1;
    localparam logic [1:0] c_err_overflow = 2'd2;
    localparam logic [1:0] c_err_checksum = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HI   = 3'd1,
        S_LO   = 3'd2,
`ifdef INST_MEM_LOADER_CHECKSUM_EN
        S_CSUM = 3'd3,
`endif
        S_FIN  = 3'd4,
        S_DONE = 3'd5,
        S_ERR  = 3'd6
    } state_t;

endpackage : inst_mem_pkg
`default_nettype wire

// File: rtl/loader_xor_acc.sv
`default_nettype none
// ============================================================================
// Module      : loader_xor_acc
// Description : 8-bit running XOR of program bytes, used as the load
//               checksum. Present only when INST_MEM_LOADER_CHECKSUM_EN is
//               defined.
// Ports       : clk, rst_n (async active-low), clr (sync clear, has priority),
//               en (fold din into acc), din[7:0], acc[7:0] (current XOR).
// Revision    : 1.0 - initial release
// ============================================================================
`ifdef INST_MEM_LOADER_CHECKSUM_EN
module loader_xor_acc (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] din,
    output logic [7:0] acc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= 8'h00;
        end else if (clr) begin
            acc <= 8'h00;
        end else if (en) begin
            acc <= acc ^ din;
        end
    end

endmodule : loader_xor_acc
`endif
`default_nettype wire

// File: rtl/inst_mem_loader.sv
`default_nettype none
// ============================================================================
// Module      : inst_mem_loader
// Description : Loads a program into instruction memory from a valid/ready
//               byte stream. Each 16-bit instruction arrives high byte first
//               and is stored big-endian (high byte at the even address).
//               Reports completion (done) or abort (err, err_code).
// Parameters  : MEM_BYTES - memory capacity in bytes (even)
//               ADDR_W    - memory address width
// Ports       : clk, rst_n (async active-low), start
//               in_valid, in_data[7:0], in_last -> in_ready
//               mem_we, mem_addr[ADDR_W-1:0], mem_wdata[7:0] (registered)
//               busy, done, err, err_code[1:0], inst_count[5:0],
//               last_inst[15:0]
// Options     : INST_MEM_LOADER_CHECKSUM_EN - after the final program byte,
//               accept one extra byte that must equal the XOR of all
//               program bytes (otherwise abort with code 3).
// Revision    : 1.0 - initial release
// ============================================================================
module inst_mem_loader
    import inst_mem_pkg::*;
#(
    parameter int MEM_BYTES = c_default_mem_bytes,
    parameter int ADDR_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [5:0]        inst_count,
    output logic [15:0]       last_inst
);

    // Pointer value of the last byte slot; writing it fills the memory.
    localparam logic [ADDR_W-1:0] c_last_ptr = ADDR_W'(MEM_BYTES - 1);
    localparam logic [5:0]        c_inst_sat = 6'd32;

    state_t            r_state;
    logic [ADDR_W-1:0] r_ptr;
    logic [7:0]        r_hi;       // high byte held until its low byte arrives
    logic              w_accept;
    logic              w_idle_like;

    assign w_accept    = in_valid && in_ready;
    assign w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR);

`ifdef INST_MEM_LOADER_CHECKSUM_EN
    logic       w_csum_clr;
    logic       w_csum_en;
    logic [7:0] w_csum;

    assign w_csum_clr = start && w_idle_like;
    assign w_csum_en  = w_accept && ((r_state == S_HI) || (r_state == S_LO));

    loader_xor_acc u_xor_acc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_csum_clr),
        .en    (w_csum_en),
        .din   (in_data),
        .acc   (w_csum)
    );

    assign in_ready = (r_state == S_HI) || (r_state == S_LO) || (r_state == S_CSUM);
    assign busy     = (r_state == S_HI) || (r_state == S_LO) || (r_state == S_CSUM)
                   || (r_state == S_FIN);
`else
    assign in_ready = (r_state == S_HI) || (r_state == S_LO);
    assign busy     = (r_state == S_HI) || (r_state == S_LO) || (r_state == S_FIN);
`endif

    assign done = (r_state == S_DONE);
    assign err  = (r_state == S_ERR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_hi       <= 8'h00;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= 8'h00;
            err_code   <= c_err_none;
            inst_count <= 6'd0;
            last_inst  <= 16'h0000;
        end else begin
            // Strobe is asserted only in the cycle after an accepted byte.
            mem_we <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        r_state    <= S_HI;
                        r_ptr      <= '0;
                        inst_count <= 6'd0;
                        err_code   <= c_err_none;
                    end
                end
                S_HI: begin
                    if (w_accept) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= r_ptr;
                        mem_wdata <= in_data;
                        r_hi      <= in_data;
                        r_ptr     <= r_ptr + ADDR_W'(1);
                        // A stream ending on a high byte is still written,
                        // then the load aborts.
                        if (in_last) begin
                            r_state  <= S_ERR;
                            err_code <= c_err_odd;
                        end else begin
                            r_state <= S_LO;
                        end
                    end
                end
                S_LO: begin
                    if (w_accept) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= r_ptr;
                        mem_wdata <= in_data;
                        r_ptr     <= r_ptr + ADDR_W'(1);
                        last_inst <= {r_hi, in_data};
                        if (inst_count != c_inst_sat) begin
                            inst_count <= inst_count + 6'd1;
                        end
                        if (in_last) begin
`ifdef INST_MEM_LOADER_CHECKSUM_EN
                            r_state <= S_CSUM;
`else
                            r_state <= S_FIN;
`endif
                        end else if (r_ptr == c_last_ptr) begin
                            r_state  <= S_ERR;
                            err_code <= c_err_overflow;
                        end else begin
                            r_state <= S_HI;
                        end
                    end
                end
`ifdef INST_MEM_LOADER_CHECKSUM_EN
                S_CSUM: begin
                    // Checksum byte is compared only, never written.
                    if (w_accept) begin
                        if (in_data == w_csum) begin
                            r_state <= S_FIN;
                        end else begin
                            r_state  <= S_ERR;
                            err_code <= c_err_checksum;
                        end
                    end
                end
`endif
                // One extra cycle so the final write lands before done.
                S_FIN: begin
                    r_state <= S_DONE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule : inst_mem_loader
`default_nettype wire

// File: doc/inst_mem_loader.md
# inst_mem_loader

Loads a program into the instruction memory as a byte stream over a valid/ready handshake. Each 16-bit instruction arrives as two bytes, high byte first, and is written big-endian: high byte at the even address, low byte at address+1. This is the write-side counterpart of the instruction-memory read/decode path. It drives the memory's byte write port and flags completion or error to the control unit.

## Interface
- `MEM_BYTES`, default 64. Byte capacity of the instruction memory; must be even. The default holds up to 32 instructions.
- `ADDR_W`, default 16. Width of the memory address bus.

Ports:
- `clk` input, 1. Single clock. All state changes on the rising edge.
- `rst_n` input, 1. Reset, asynchronous and active-low.
- `start` input, 1. Pulse that begins a load from address 0.
- `in_valid` input, 1. Byte available.
- `in_data` input, 8. Program byte.
- `in_last` input, 1. Marks the final program byte; qualified by `in_valid`.
- `in_ready` output, 1. Loader accepts a byte.
- `mem_we` output, 1. Byte write strobe to instruction memory.
- `mem_addr` output, ADDR_W. Write address.
- `mem_wdata` output, 8. Write data.
- `busy` output, 1. Load in progress.
- `done` output, 1. Load completed successfully.
- `err` output, 1. Load aborted.
- `err_code` output, 2. Abort cause: 0 none, 1 odd length, 2 overflow, 3 checksum.
- `inst_count` output, 6. Number of complete instructions written.
- `last_inst` output, 16. {high, low} of the most recently completed instruction.

## Operation
- FSM states: IDLE, HI, LO, CSUM (only with macro), FIN, DONE, ERR.
- A byte is accepted in any cycle where `in_valid && in_ready` is true.
- `in_ready` is 1 only in HI, LO and CSUM.
- IDLE, DONE, ERR:
  - `start` → HI.
  - Clears the byte pointer, `inst_count`, `err_code`, and the checksum.
- In any other state, `start` is ignored.
- HI, on accept:
  - Byte is written to pointer p; p increments; → LO.
  - If `in_last`=1 → ERR with code 1 (odd length). The byte is still written.
- LO, on accept:
  - Byte is written to p; p increments.
  - `inst_count` increments and `last_inst` updates.
  - If `in_last`=1 → FIN (or CSUM with macro).
  - Else, if p has reached `MEM_BYTES` → ERR with code 2 (overflow).
  - Else → HI.
- FIN → DONE unconditionally.
- DONE and ERR hold until `start`.
- `busy` is 1 in HI, LO, CSUM and FIN.
- `done` = (state == DONE). `err` = (state == ERR).
- `inst_count` saturates at 32. It cannot exceed 32, because overflow aborts first.
- Memory contents are never cleared by this block.

## Timing
- Writes are registered. A byte accepted in cycle N appears in cycle N+1 as `mem_we`=1, with `mem_addr` = its pointer and `mem_wdata` = the byte.
- `mem_we` is 0 in every cycle without a preceding accept.
- For a final low byte accepted in cycle N:
  - Final write occurs in N+1.
  - `done` is first 1 in N+2, so the memory is fully written before `done`.
- For an error-causing byte accepted in cycle N, `err` is first 1 in N+1.
- Back-to-back accepts are allowed at full rate, one byte per cycle.
- Reset values:
  - State IDLE.
  - `in_ready`, `mem_we`, `busy`, `done`, `err` all 0.
  - `err_code`, `inst_count`, `last_inst`, `mem_addr`, `mem_wdata` all 0.
- Reset mid-load aborts immediately. A write pending from the previous cycle is dropped.

## Configuration
- Macro `INST_MEM_LOADER_CHECKSUM_EN`.
- Defined:
  - An 8-bit XOR of all program bytes accumulates.
  - After the `in_last` low byte, the FSM goes to CSUM and accepts one extra byte. That byte is not written to memory.
  - If it equals the XOR → FIN. Otherwise → ERR with code 3.
  - `in_last` is ignored in CSUM.
- Undefined:
  - No CSUM state and no accumulator.
  - Error code 3 is never produced.

## Structure
- Shared package `inst_mem_pkg` holds:
  - the FSM state enum;
  - error code constants;
  - the default `MEM_BYTES`;
  - the instruction field widths (opcode 4, register 3, imm 5), shared with the read/decode side.
- Optional sub-module `loader_xor_acc`: checksum accumulator with clear and enable. It is instantiated only under the macro.

## Test plan
- **Normal load:** `start`, then bytes 0x12,0x34,0x56,0x78 (last on 0x78) at full rate.
  - Writes go to addresses 0..3 in order.
  - `inst_count`=2, `last_inst`=0x5678.
  - `done` rises 2 cycles after the final accept.
- **Odd length:** bytes 0xAA,0xBB,0xCC with last on 0xCC.
  - 0xCC is written to address 2.
  - `err`=1, `err_code`=1, `inst_count`=1.
- **Overflow:** 64 bytes with no `in_last`.
  - 64 writes occur.
  - `err_code`=2, `inst_count`=32, `in_ready` drops.
- **Backpressure and gaps:** toggle `in_valid` randomly, and pulse `start` mid-load.
  - Identical memory image to the full-rate case.
  - `start` has no effect.
- **Reset mid-load:** assert `rst_n`=0 after 3 accepted bytes.
  - All outputs return to reset values.
  - No further `mem_we`.
  - A new `start` reloads from address 0.
- **Checksum (macro defined):** program 0x12,0x34, then checksum byte 0x26.
  - Result: `done`.
  - With checksum byte 0x27 instead: `err_code`=3, and only 2 writes occur.
